seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, handshaked successor to the team's 16-bit combinational ALU. It keeps the same 4-bit opcode map and adds three things:

- operand width set by parameter;
- multi-bit shifts and rotates, with the amount taken from operand B;
- a registered result held behind valid/ready handshakes.

It sits between the decode/issue stage and writeback. Shifts execute iteratively, one bit per cycle, unless the single-cycle barrel shifter is compiled in.

## Interface
- WIDTH, 16, operand/result width; power of two, 4 to 64.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request present.
- in_ready  output  1  block can accept a request.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B; for shifts, B[SHW-1:0] is the shift amount.
- OP  input  4  opcode.
- out_valid  output  1  C/Cout hold a valid result.
- out_ready  input  1  consumer accepts the result.
- C  output  WIDTH  result.
- Cout  output  1  signed overflow flag for add/sub; 0 for every other op.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - SHIFT: iterative shift in progress.
  - DONE: out_valid=1.
- Accept: in_valid && in_ready. On accept, A, B[SHW-1:0] and OP are captured into internal registers. Inputs are don't-care after that.
- Opcodes:
  - 0000 add: C = A+B mod 2^WIDTH. Cout=1 iff A and B have the same sign and the sign of C differs from it.
  - 0001 sub: C = A-B mod 2^WIDTH. Cout=1 iff A and B have different signs and the sign of C differs from the sign of A.
  - 0010 AND, 0011 OR, 0100 NAND, 0101 NOR, 0110 XOR, 0111 XNOR.
  - 1000 pass A; 1001 ~A.
  - 1010 logical right; 1011 arithmetic right (sign fill); 1100 rotate right.
  - 1101 logical left; 1110 arithmetic left (identical to logical left); 1111 rotate left.
- Shift amount s = B[SHW-1:0], range 0 to WIDTH-1. Upper bits of B are ignored.
- Non-shift ops: IDLE → DONE. Result is registered on the accept edge.
- Shift ops, iterative build:
  - s==0: IDLE → DONE with C=A.
  - s>0: IDLE → SHIFT. The working register is loaded with A and a counter with s. Each SHIFT cycle shifts by one bit and decrements the counter. When the counter reaches 0, the FSM goes SHIFT → DONE.
- DONE → IDLE on out_ready. C and Cout hold their values and stay stable while out_valid && !out_ready.
- No new request is accepted outside IDLE.
- Cout is 0 for every opcode other than 0000 and 0001.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, C=0, Cout=0, internal counter=0.
- Reset is asynchronous: asserting it mid-SHIFT or in DONE drops out_valid immediately, and the in-flight op is discarded.
- Latency is measured from the accept edge to the first edge at which out_valid=1:
  - 1 cycle for non-shift ops and for shifts with s==0;
  - 1+s cycles for iterative shifts with s>0.
- Result transfer occurs on the edge where out_valid && out_ready. The FSM is in IDLE on the following cycle.
- Maximum throughput is one op per 2 cycles.
- out_ready held high in advance is allowed. The result still transfers only on a DONE cycle.
- in_ready is a function of state only. It never depends combinationally on in_valid or out_ready.

## Configuration
- SEQ_ALU_BARREL_EN defined: every shift/rotate completes in a single cycle via a combinational barrel shifter. The SHIFT state and counter are not built, and latency is 1 for all ops.
- SEQ_ALU_BARREL_EN undefined: the iterative shifter is used, with latency 1+s as above.
- Functional results are identical in both builds.

## Test plan
- WIDTH=16, add A=0x7FFF B=0x0001 → C=0x8000, Cout=1, out_valid one cycle after accept. Add 0xFFFF+0x0001 → C=0x0000, Cout=0.
- Sub A=0x8000 B=0x0001 → C=0x7FFF, Cout=1. Sub 0x0005-0x0007 → C=0xFFFE, Cout=0.
- Arithmetic right A=0x8000, B=0x0003 → C=0xF000. out_valid at 4 cycles (iterative) or 1 cycle (SEQ_ALU_BARREL_EN). B=0xFFF3 gives the same result, since upper bits are ignored.
- Rotate left A=0x8001, B=4 → C=0x0018. Rotate right with s=0 → C=A at latency 1.
- Backpressure: complete an XOR of 0xF0F0 and 0x0FF0 → C=0xFF00, then hold out_ready=0 for 5 cycles. C stays stable, in_ready=0, and a new in_valid is ignored. The op is accepted only after the result transfers and the FSM returns to IDLE.
- Assert reset in the 2nd SHIFT cycle of a shift with s=7 → out_valid=0, C=0, in_ready=1 immediately. A subsequent add completes normally.

Source files
------------

// File: rtl/seq_alu.sv
// Handshaked, parametrised ALU with a registered result; shifts run one bit per cycle
// unless SEQ_ALU_BARREL_EN is defined, which swaps in a single-cycle barrel shifter.
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       OP,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic             Cout
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] c_r;
  logic             cout_r;

`ifdef SEQ_ALU_BARREL_EN
  function automatic logic [WIDTH-1:0] shift_full(input logic [WIDTH-1:0] a,
                                                  input logic [SHW-1:0]   s,
                                                  input logic [3:0]       op);
    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH-1:0]   r;
    dbl = {a, a};
    r   = a;
    case (op)
      4'hA:       r = a >> s;
      4'hB:       r = unsigned'(signed'(a) >>> s);
      4'hC:       begin dbl = dbl >> s; r = dbl[WIDTH-1:0]; end
      4'hD, 4'hE: r = a << s;
      4'hF:       begin dbl = dbl << s; r = dbl[2*WIDTH-1:WIDTH]; end
      default:    r = a;
    endcase
    return r;
  endfunction
`else
  // Single-bit step used by the iterative shifter; arithmetic left equals logical left.
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v,
                                                 input logic [3:0]       op);
    logic [WIDTH-1:0] r;
    case (op)
      4'hA:       r = {1'b0, v[WIDTH-1:1]};
      4'hB:       r = {v[WIDTH-1], v[WIDTH-1:1]};
      4'hC:       r = {v[0], v[WIDTH-1:1]};
      4'hD, 4'hE: r = {v[WIDTH-2:0], 1'b0};
      4'hF:       r = {v[WIDTH-2:0], v[WIDTH-1]};
      default:    r = v;
    endcase
    return r;
  endfunction
`endif

  // Returns {overflow, result}. Iterative shifts start from A, which is also the s==0 result.
  function automatic logic [WIDTH:0] alu_comb(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [3:0]       op);
    logic signed [WIDTH-1:0] sa, sb, sr;
    logic [WIDTH-1:0]        r;
    logic                    ovf;
    sa  = signed'(a);
    sb  = signed'(b);
    sr  = '0;
    r   = '0;
    ovf = 1'b0;
    case (op)
      4'h0: begin
        sr  = sa + sb;
        r   = unsigned'(sr);
        ovf = (sa[WIDTH-1] == sb[WIDTH-1]) && (sr[WIDTH-1] != sa[WIDTH-1]);
      end
      4'h1: begin
        sr  = sa - sb;
        r   = unsigned'(sr);
        ovf = (sa[WIDTH-1] != sb[WIDTH-1]) && (sr[WIDTH-1] != sa[WIDTH-1]);
      end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = ~(a & b);
      4'h5: r = ~(a | b);
      4'h6: r = a ^ b;
      4'h7: r = ~(a ^ b);
      4'h8: r = a;
      4'h9: r = ~a;
`ifdef SEQ_ALU_BARREL_EN
      default: r = shift_full(a, b[SHW-1:0], op);
`else
      default: r = a;
`endif
    endcase
    return {ovf, r};
  endfunction

`ifndef SEQ_ALU_BARREL_EN
  logic [SHW-1:0] cnt;
  logic [3:0]     op_r;
  logic [SHW-1:0] amt;
  logic           is_shift;
  assign amt      = B[SHW-1:0];
  assign is_shift = OP[3] & (OP[2] | OP[1]);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      c_r    <= '0;
      cout_r <= 1'b0;
`ifndef SEQ_ALU_BARREL_EN
      cnt    <= '0;
      op_r   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            {cout_r, c_r} <= alu_comb(A, B, OP);
`ifdef SEQ_ALU_BARREL_EN
            state <= DONE;
`else
            op_r  <= OP;
            cnt   <= amt;
            state <= (is_shift && (amt != '0)) ? SHIFT : DONE;
`endif
          end
        end
`ifndef SEQ_ALU_BARREL_EN
        SHIFT: begin
          c_r <= shift_one(c_r, op_r);
          cnt <= cnt - SHW'(1);
          if (cnt == SHW'(1)) state <= DONE;
        end
`endif
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign C         = c_r;
  assign Cout      = cout_r;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=16): directed vector table, backpressure and
// async-reset sequences, then randomized ops against an arithmetic reference model.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A, B;
  logic [3:0]  OP;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] C;
  logic        Cout;

  int checks = 0;
  int errors = 0;

  seq_alu #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .OP(OP), .out_valid(out_valid), .out_ready(out_ready),
    .C(C), .Cout(Cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic [15:0] c;
    logic        co;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int iter_lat);
`ifdef SEQ_ALU_BARREL_EN
    return (iter_lat > 0) ? 1 : iter_lat;
`else
    return iter_lat;
`endif
  endfunction

  // Reference from the arithmetic meaning of each opcode.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                                output logic [15:0] c, output logic co, output int lat);
    int sa, sb, r, s;
    logic [31:0] dbl;
    sa = $signed(a);
    sb = $signed(b);
    s  = int'(b[3:0]);
    dbl = {a, a};
    co = 1'b0;
    r  = 0;
    c  = 16'h0;
    case (op)
      4'h0: begin r = sa + sb; c = r[15:0]; co = (r > 32767) || (r < -32768); end
      4'h1: begin r = sa - sb; c = r[15:0]; co = (r > 32767) || (r < -32768); end
      4'h2: c = a & b;
      4'h3: c = a | b;
      4'h4: c = ~(a & b);
      4'h5: c = ~(a | b);
      4'h6: c = a ^ b;
      4'h7: c = ~(a ^ b);
      4'h8: c = a;
      4'h9: c = ~a;
      4'hA: c = a >> s;
      4'hB: begin r = sa >>> s; c = r[15:0]; end
      4'hC: begin dbl = dbl >> s; c = dbl[15:0]; end
      4'hD, 4'hE: c = a << s;
      default: begin dbl = dbl >> (16 - s); c = dbl[15:0]; end
    endcase
    lat = (op >= 4'hA && s > 0) ? lat_of(1 + s) : 1;
  endfunction

  task automatic wait_idle();
    int w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
  endtask

  // Issue one op, measure accept-to-out_valid latency, capture the result, then drain it.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                       output logic [15:0] c, output logic co, output int lat);
    @(negedge clk);
    wait_idle();
    A = a; B = b; OP = op; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = 16'($urandom); B = 16'($urandom); OP = 4'($urandom);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    c = C;
    co = Cout;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  vec_t tbl[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] c, ec;
    logic        co, eco;
    int          lat, elat;

    tbl[0]  = '{16'h7FFF, 16'h0001, 4'h0, 16'h8000, 1'b1, 1};
    tbl[1]  = '{16'hFFFF, 16'h0001, 4'h0, 16'h0000, 1'b0, 1};
    tbl[2]  = '{16'h8000, 16'h0001, 4'h1, 16'h7FFF, 1'b1, 1};
    tbl[3]  = '{16'h0005, 16'h0007, 4'h1, 16'hFFFE, 1'b0, 1};
    tbl[4]  = '{16'h8000, 16'h0003, 4'hB, 16'hF000, 1'b0, 4};
    tbl[5]  = '{16'h8000, 16'hFFF3, 4'hB, 16'hF000, 1'b0, 4};
    tbl[6]  = '{16'h8001, 16'h0004, 4'hF, 16'h0018, 1'b0, 5};
    tbl[7]  = '{16'h1234, 16'h0000, 4'hC, 16'h1234, 1'b0, 1};
    tbl[8]  = '{16'hF0F0, 16'h0FF0, 4'h6, 16'hFF00, 1'b0, 1};
    tbl[9]  = '{16'hFF00, 16'h0F0F, 4'h4, 16'hF0FF, 1'b0, 1};
    tbl[10] = '{16'h1234, 16'h5555, 4'h9, 16'hEDCB, 1'b0, 1};
    tbl[11] = '{16'h8000, 16'h000F, 4'hA, 16'h0001, 1'b0, 16};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; OP = '0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_c", C, 0);
    chk("reset_cout", Cout, 0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].op, c, co, lat);
      chk($sformatf("vec%0d_c", i), c, tbl[i].c);
      chk($sformatf("vec%0d_cout", i), co, tbl[i].co);
      chk($sformatf("vec%0d_lat", i), lat, lat_of(tbl[i].lat));
      @(negedge clk);
      chk($sformatf("vec%0d_idle", i), {out_valid, in_ready}, 2'b01);
    end

    // Backpressure: result held while a competing request waits.
    @(negedge clk);
    A = 16'hF0F0; B = 16'h0FF0; OP = 4'h6; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 A = 16'h0001; B = 16'h0002; OP = 4'h0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_valid%0d", k), out_valid, 1);
      chk($sformatf("bp_c%0d", k), C, 16'hFF00);
      chk($sformatf("bp_in_ready%0d", k), in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_after_xfer", {out_valid, in_ready}, 2'b01);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_c", C, 16'h0003);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;

    // Async reset in the second SHIFT cycle of a 7-bit shift.
    @(negedge clk);
    wait_idle();
    A = 16'hFFFF; B = 16'h0007; OP = 4'hA; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_c", C, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    do_op(16'h1000, 16'h0234, 4'h0, c, co, lat);
    chk("post_rst_c", c, 16'h1234);
    chk("post_rst_cout", co, 0);
    chk("post_rst_lat", lat, 1);

    for (int n = 0; n < 200; n++) begin
      logic [15:0] ra, rb;
      logic [3:0]  rop;
      ra = 16'($urandom); rb = 16'($urandom); rop = 4'($urandom_range(0, 15));
      model(ra, rb, rop, ec, eco, elat);
      do_op(ra, rb, rop, c, co, lat);
      chk($sformatf("rnd%0d_op%0h_c", n, rop), c, ec);
      chk($sformatf("rnd%0d_op%0h_cout", n, rop), co, eco);
      chk($sformatf("rnd%0d_op%0h_lat", n, rop), lat, elat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
